regpair_file: RTL
=================

REGPAIR_FILE -- requirements
Module: regpair_file

Interface
REQ-001 SHALL have parameter DW, default 8, data byte width.
REQ-002 SHALL have parameter NPAIRS, default 6, number of register pairs (min 2).
REQ-003 SHALL have parameter PC_IDX, default 4, index of the program-counter pair.
REQ-004 SHALL have parameter PC_RST, default 0 (AW bits), reset value of pair PC_IDX; derived AW = 2*DW, SW = clog2(NPAIRS).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port op_valid  input  1  operation request.
REQ-008 SHALL have port op_ready  output  1  block can accept an operation.
REQ-009 SHALL have port op_code  input  3  0 NOP, 1 WRBYTE, 2 RDBYTE, 3 LDADDR, 4 INC1, 5 INC2, 6 DEC1, 7 DEC2.
REQ-010 SHALL have port op_sel  input  SW  target pair index.
REQ-011 SHALL have port op_hi  input  1  byte half for WRBYTE/RDBYTE (1 = bits AW-1:DW).
REQ-012 SHALL have port wdata  input  DW  write byte.
REQ-013 SHALL have port rdata  output  DW  read byte.
REQ-014 SHALL have port rdata_valid  output  1  one-cycle pulse qualifying rdata.
REQ-015 SHALL have port address  output  AW  registered address latch.
REQ-016 SHALL have port carry_out  output  1  carry/borrow of last inc/dec.

Function
REQ-017 SHALL accept an operation on a rising edge where op_valid && op_ready; otherwise inputs are ignored.
REQ-018 SHALL implement FSM states IDLE, CALC, WB; op_ready = 1 only in IDLE.
REQ-019 SHALL, for NOP, stay in IDLE with no state change.
REQ-020 SHALL, for WRBYTE, write wdata into selected half of pair op_sel on the accepting edge; stay IDLE.
REQ-021 SHALL, for RDBYTE, drive selected half of pair op_sel on rdata with rdata_valid = 1 in the cycle after acceptance; rdata_valid = 0 otherwise; rdata holds last value.
REQ-022 SHALL, for LDADDR, load address with pair op_sel on the accepting edge; stay IDLE.
REQ-023 SHALL, for INC1/INC2/DEC1/DEC2: accept edge loads address with pair, goes CALC; CALC edge registers result = address ±1 or ±2 and carry_out, goes WB; WB edge writes result into pair op_sel (latched at accept), goes IDLE.
REQ-024 SHALL give inc/dec a 3-cycle occupancy: next op accepted on the edge after WB.
REQ-025 SHALL compute result modulo 2^AW; carry_out = 1 on increment overflow past 2^AW-1, or decrement borrow below 0; else 0.
REQ-026 SHALL leave address unchanged by the inc/dec result (address shows pre-operation value).
REQ-027 SHALL treat op_sel >= NPAIRS as no-op on all pairs; RDBYTE still pulses rdata_valid with rdata = 0; inc/dec still sequences FSM with address = 0.
REQ-028 SHALL give WRBYTE and the WB write to the same pair no conflict, as WRBYTE is not accepted outside IDLE.
REQ-029 SHALL hold carry_out until the next CALC state.

Reset
REQ-030 SHALL, while rst = 1 on a rising edge, set all pairs to 0 except pair PC_IDX = PC_RST.
REQ-031 SHALL reset address = 0, rdata = 0, rdata_valid = 0, carry_out = 0, FSM = IDLE (op_ready = 1 the cycle after reset releases).
REQ-032 SHALL abort any in-flight inc/dec on reset; no writeback occurs and the pair takes its reset value.
REQ-033 SHALL give rst priority over any concurrent op_valid.

Verification
REQ-034 SHALL cover WRBYTE pair 0 lo = 0x34, hi = 0x12, then RDBYTE hi -> rdata = 0x12, rdata_valid pulse next cycle.
REQ-035 SHALL cover pair 4 after reset (PC_RST = 0x0100), INC1 -> address = 0x0100 in CALC, pair 4 = 0x0101 after WB, carry_out = 0, op_ready low 2 cycles.
REQ-036 SHALL cover pair 1 = 0xFFFF, INC2 -> pair 1 = 0x0001, carry_out = 1.
REQ-037 SHALL cover pair 2 = 0x0001, DEC2 -> pair 2 = 0xFFFF, carry_out = 1; DEC1 on 0x0005 -> 0x0004, carry_out = 0.
REQ-038 SHALL cover rst asserted in CALC of INC1 on pair 3 = 0x00AA -> pair 3 = 0x0000, FSM IDLE, no writeback.
REQ-039 SHALL cover op_valid held high while busy -> only the first op executes; op_sel = 7 with NPAIRS = 6 -> no pair changes.

Source files
------------

// File: rtl/regpair_file.sv
// Register-pair file: NPAIRS registers of 2*DW bits with byte access, an address
// latch and a three-cycle increment/decrement path that writes back into the pair.
module regpair_file #(
  parameter int unsigned     DW     = 8,
  parameter int unsigned     NPAIRS = 6,
  parameter int unsigned     PC_IDX = 4,
  parameter logic [2*DW-1:0] PC_RST = '0,
  localparam int unsigned    AW     = 2 * DW,
  localparam int unsigned    SW     = $clog2(NPAIRS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    op_code,
  input  logic [SW-1:0] op_sel,
  input  logic          op_hi,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic [AW-1:0] address,
  output logic          carry_out
);

  localparam logic [2:0] OpNop    = 3'd0;
  localparam logic [2:0] OpWrByte = 3'd1;
  localparam logic [2:0] OpRdByte = 3'd2;
  localparam logic [2:0] OpLdAddr = 3'd3;

  typedef enum logic [1:0] {StIdle, StCalc, StWb} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pair_q [NPAIRS];
  logic [AW-1:0] pair_d [NPAIRS];
  logic [AW-1:0] address_q, address_d;
  logic [AW-1:0] result_q, result_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rdata_valid_q, rdata_valid_d;
  logic          carry_q, carry_d;
  logic [SW-1:0] wb_sel_q, wb_sel_d;
  logic          wb_en_q, wb_en_d;
  logic          dec_q, dec_d;
  logic          two_q, two_d;

  logic          accept;
  logic          sel_ok;
  logic [AW-1:0] sel_pair;
  logic [AW:0]   step;
  logic [AW:0]   sum;

  assign accept   = op_valid && (state_q == StIdle);
  assign sel_ok   = 32'(op_sel) < NPAIRS;
  assign sel_pair = sel_ok ? pair_q[op_sel] : '0;

  // One extra bit on the sum captures both increment carry and decrement borrow.
  always_comb begin
    step      = '0;
    step[1:0] = two_q ? 2'd2 : 2'd1;
    sum       = dec_q ? ({1'b0, address_q} - step) : ({1'b0, address_q} + step);
  end

  always_comb begin
    state_d       = state_q;
    pair_d        = pair_q;
    address_d     = address_q;
    result_d      = result_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    carry_d       = carry_q;
    wb_sel_d      = wb_sel_q;
    wb_en_d       = wb_en_q;
    dec_d         = dec_q;
    two_d         = two_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (op_code)
            OpNop: ;
            OpWrByte: begin
              if (sel_ok) begin
                if (op_hi) pair_d[op_sel][AW-1:DW] = wdata;
                else       pair_d[op_sel][DW-1:0]  = wdata;
              end
            end
            OpRdByte: begin
              rdata_d       = op_hi ? sel_pair[AW-1:DW] : sel_pair[DW-1:0];
              rdata_valid_d = 1'b1;
            end
            OpLdAddr: address_d = sel_pair;
            default: begin
              // INC1/INC2/DEC1/DEC2: bit 1 selects decrement, bit 0 a step of two.
              address_d = sel_pair;
              wb_sel_d  = op_sel;
              wb_en_d   = sel_ok;
              dec_d     = op_code[1];
              two_d     = op_code[0];
              state_d   = StCalc;
            end
          endcase
        end
      end
      StCalc: begin
        result_d = sum[AW-1:0];
        carry_d  = sum[AW];
        state_d  = StWb;
      end
      StWb: begin
        if (wb_en_q) pair_d[wb_sel_q] = result_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      for (int i = 0; i < int'(NPAIRS); i++) begin
        pair_q[i] <= (i == int'(PC_IDX)) ? PC_RST : '0;
      end
      address_q     <= '0;
      result_q      <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      carry_q       <= 1'b0;
      wb_sel_q      <= '0;
      wb_en_q       <= 1'b0;
      dec_q         <= 1'b0;
      two_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pair_q        <= pair_d;
      address_q     <= address_d;
      result_q      <= result_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      carry_q       <= carry_d;
      wb_sel_q      <= wb_sel_d;
      wb_en_q       <= wb_en_d;
      dec_q         <= dec_d;
      two_q         <= two_d;
    end
  end

  assign op_ready    = (state_q == StIdle);
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign address     = address_q;
  assign carry_out   = carry_q;

endmodule
